// File: rtl/io_status_pkg.sv
// Shared constants and types for the user-status pad arbiter.
package io_status_pkg;

    // Width of the mprj_io[37:20] status field: 2-bit phase + 16-bit value.
    localparam int STATUS_W = 18;

    // Phase codes carried in the top two bits of every report.
    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_RUN  = 2'b01;
    localparam logic [1:0] PH_DONE = 2'b10;
    localparam logic [1:0] PH_ERR  = 2'b11;

    // Arbiter FSM state. busy_o mirrors the state directly, so the state is
    // always observable at the top-level boundary.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_HOLD = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the scan starts at ptr_i and wraps,
// so the first requester at or after the pointer wins.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [2:0]      ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [2:0]      idx_o
);

    logic [3:0] cand;
    logic       found;

    // Walk the requesters in priority order starting at the pointer.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_i} + 4'(k);
            if (cand >= 4'(NREQ)) begin
                cand = cand - 4'(NREQ);
            end
            for (int j = 0; j < NREQ; j++) begin
                if (en_i && !found && req_i[j] && (cand == 4'(j))) begin
                    found    = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = 3'(j);
                end
            end
        end
    end

endmodule

// File: rtl/io_status_arbiter.sv
// Shares the 18-bit user status pads between NREQ requesters. Each accepted
// report is held on the pads for at least DWELL cycles so that an external
// monitor can sample it; the last report persists until the next one.
//
// Handshake: a requester raises req_valid_i[i] with phase/data stable and
// keeps them stable until req_ready_o[i] is seen high; a transfer happens in
// exactly the cycle where valid[i] & ready[i] are both high. Ready is one-hot,
// combinational, and only ever asserted in IDLE with enable_i high. Dropping
// valid before ready withdraws the request without side effects.
module io_status_arbiter
    import io_status_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = 16,
    parameter int DWELL  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   enable_i,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [2*NREQ-1:0]      req_phase_i,
    input  logic [DATA_W*NREQ-1:0] req_data_i,
    output logic [DATA_W+1:0]      io_out_o,
    output logic [DATA_W+1:0]      io_oeb_o,
    output logic                   busy_o,
    output logic [2:0]             grant_id_o,
    output logic [CNT_W-1:0]       report_cnt_o
);

    localparam int OUT_W   = DATA_W + 2;
    localparam int DWELL_W = (DWELL > 2) ? $clog2(DWELL) : 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    state_t              state_q, state_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [OUT_W-1:0]    io_out_q, io_out_d;
    logic [OUT_W-1:0]    oeb_q, oeb_d;
    logic [2:0]          grant_id_q, grant_id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                arb_en;
    logic [NREQ-1:0]     gnt;
    logic [2:0]          gnt_idx;
    logic                accept;
    logic [1:0]          win_phase;
    logic [DATA_W-1:0]   win_data;
    logic [2:0]          ptr_next;

    // Grants only in IDLE with the arbiter enabled; the reset term keeps
    // ready low while reset is held, whatever the requesters present.
    assign arb_en = (state_q == ST_IDLE) && enable_i && wb_rst_ni;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign accept      = |gnt;
    assign req_ready_o = gnt;
    assign ptr_next    = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;

    // Select the winning requester's phase and value using the one-hot grant.
    always_comb begin
        win_phase = '0;
        win_data  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (gnt[j]) begin
                win_phase = req_phase_i[2*j +: 2];
                win_data  = req_data_i[DATA_W*j +: DATA_W];
            end
        end
    end

    // FSM next state: latch a report on accept, then count out the dwell.
    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        ptr_d      = ptr_q;
        io_out_d   = io_out_q;
        grant_id_d = grant_id_q;
        cnt_d      = cnt_q;
        oeb_d      = {OUT_W{~enable_i}};
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    io_out_d   = {win_phase, win_data};
                    grant_id_d = gnt_idx;
                    cnt_d      = cnt_q + CNT_ONE;
                    ptr_d      = ptr_next;
                    dwell_d    = '0;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                dwell_d = dwell_q + DWELL_ONE;
                if (dwell_q == DWELL_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight report.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= ST_IDLE;
            dwell_q    <= '0;
            ptr_q      <= '0;
            io_out_q   <= '0;
            oeb_q      <= '1;
            grant_id_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            ptr_q      <= ptr_d;
            io_out_q   <= io_out_d;
            oeb_q      <= oeb_d;
            grant_id_q <= grant_id_d;
            cnt_q      <= cnt_d;
        end
    end

    assign io_out_o     = io_out_q;
    assign io_oeb_o     = oeb_q;
    assign busy_o       = (state_q == ST_HOLD);
    assign grant_id_o   = grant_id_q;
    assign report_cnt_o = cnt_q;

endmodule

// File: doc/io_status_arbiter.md
Name: io_status_arbiter

Overview:
- Schedules and shares the 18-bit user status field mprj_io[37:20] between NREQ on-chip requesters, such as LA test engines and the WB firmware mailbox.
- Each accepted report is a 2-bit phase ([37:36]) plus a 16-bit value ([35:20]).
- Each report is held for a guaranteed minimum dwell so external monitors and testbenches can sample it.
- Sits in the user project between the test engines and the io_out/io_oeb pads.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 16, status value width.
- DWELL, 8, minimum cycles a granted report stays on the pads (>=2).
- CNT_W, 8, width of the accepted-report counter.

Ports:
- wb_clk_i  input  1  system clock.
- wb_rst_ni  input  1  asynchronous active-low reset.
- enable_i  input  1  arbiter enable (LA-controlled).
- req_valid_i  input  NREQ  per-requester report valid.
- req_ready_o  output  NREQ  per-requester accept, one-hot, combinational.
- req_phase_i  input  2*NREQ  phase codes, requester i at [2i+1:2i].
- req_data_i  input  DATA_W*NREQ  values, requester i at [DATA_W*i +: DATA_W].
- io_out_o  output  DATA_W+2  to mprj_io[37:20]; {phase, value}.
- io_oeb_o  output  DATA_W+2  pad output-enable bar.
- busy_o  output  1  high in HOLD.
- grant_id_o  output  3  index of the last granted requester.
- report_cnt_o  output  CNT_W  count of accepted reports.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - FSM=IDLE; io_out_o=0; io_oeb_o=all 1s; busy_o=0; grant_id_o=0; report_cnt_o=0.
  - Round-robin pointer=0; req_ready_o=0.
- io_oeb_o is registered: all 0s the cycle after enable_i=1, all 1s the cycle after enable_i=0.
- FSM states: IDLE, HOLD.
- IDLE:
  - If enable_i=1 and any req_valid_i is set, the round-robin winner gets req_ready_o[w]=1 in the same cycle; the handshake is valid&ready.
  - On the next edge: io_out_o <= {phase_w, data_w}; grant_id_o <= w; report_cnt_o++ (wraps at 2^CNT_W); pointer <= (w+1) mod NREQ; dwell counter <= 0; state <= HOLD.
- HOLD:
  - No req_ready_o is asserted; the counter increments each cycle.
  - When the counter equals DWELL-1, state <= IDLE.
  - A report is therefore visible for at least DWELL cycles, and for DWELL+1 cycles when back-to-back, because the next grant occurs in IDLE.
- No pending request: io_out_o keeps the last report indefinitely; it never returns to 0 except on reset.
- Round robin: priority starts at the pointer and scans upward with wrap. A requester holding valid is granted within NREQ grants (no starvation).
- Requesters must hold valid, phase and data stable until ready. Dropping valid before ready withdraws the request silently.
- enable_i=0:
  - No grants are issued.
  - If in HOLD, the dwell completes and the FSM returns to IDLE, where it waits.
  - io_out_o retains its value; io_oeb_o goes high.
- Simultaneous valid from all requesters with pointer=p: grant order is p, p+1, … mod NREQ.
- Reset mid-HOLD: immediate return to reset values; the in-flight report is discarded.
- grant_id_o is zero-extended when NREQ<8.

Decomposition:
- io_status_pkg holds:
  - Phase constants: PH_IDLE=2'b00, PH_RUN=2'b01, PH_DONE=2'b10, PH_ERR=2'b11.
  - STATUS_W=18.
  - The FSM state typedef.
- One sub-module, rr_arbiter (NREQ parameter): inputs req vector, pointer, en; outputs one-hot grant and encoded index. It is combinational.
- The top level owns the FSM, dwell counter, pointer and output registers.

Test Plan:
- Single report: after reset, enable_i=1, req 1 valid with phase=2'b10, data=16'h0001 → ready[1] high for one cycle; next cycle io_out_o=18'h20001, io_oeb_o=0; held ≥8 cycles; report_cnt_o=1; grant_id_o=1.
- Fairness: all 4 requesters continuously valid with distinct data 16'hA0..A3 → grant order 0,1,2,3,0; each value on the pads for exactly 9 cycles (DWELL+1).
- Dwell guarantee: req 2 raises valid one cycle after req 0's grant → req 2 is not accepted until req 0's value has been visible for 8 cycles.
- Enable gating: enable_i dropped during HOLD with req 3 pending → current dwell completes, no grant; io_oeb_o=all 1s; io_out_o unchanged; re-assert enable_i → req 3 granted.
- Reset mid-operation: assert wb_rst_ni low during HOLD → immediately io_out_o=0, io_oeb_o=all 1s, report_cnt_o=0, busy_o=0.
- Counter wrap: 256 accepted reports → report_cnt_o returns to 0; no loss of grants.
